// File: rtl/cva6_timer_periph_if.sv
// Core data-bus port bundle for the timer peripheral: single-cycle request, combinational response.
interface cva6_timer_periph_if;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_valid;

  modport master (
    output data_req, data_we, data_be, data_addr, data_wdata,
    input  data_rdata, data_valid
  );

  modport slave (
    input  data_req, data_we, data_be, data_addr, data_wdata,
    output data_rdata, data_valid
  );
endinterface

// File: rtl/cva6_timer_periph.sv
// Memory-mapped timer: prescaled 32-bit up-counter, compare match with sticky
// status, and a level interrupt, in a 16-byte window on the core data bus.
module cva6_timer_periph #(
  parameter logic [31:0] BASE_ADDR  = 32'h2000_1000,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  cva6_timer_periph_if.slave  bus,
  output logic                irq
);

  logic                  en_q, auto_reload_q, irq_en_q;
  logic [PRESCALE_W-1:0] prescale_q, presc_q, prescale_nxt;
  logic [31:0]           count_q, compare_q;
  logic                  match_q;

  logic        sel, wr;
  logic [1:0]  idx;
  logic        wr_ctrl, wr_count, wr_compare, wr_status, clr_match;
  logic        tick, hit;
  logic [31:0] ctrl_rd, count_tick, count_nxt;
  logic        unused_addr_bits;

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  assign sel        = (bus.data_addr[31:4] == BASE_ADDR[31:4]);
  assign idx        = bus.data_addr[3:2];
  assign wr         = bus.data_req & bus.data_we & sel;
  assign wr_ctrl    = wr & (idx == 2'd0);
  assign wr_count   = wr & (idx == 2'd1);
  assign wr_compare = wr & (idx == 2'd2);
  assign wr_status  = wr & (idx == 2'd3);
  assign clr_match  = wr_status & bus.data_be[0] & bus.data_wdata[0];

  assign unused_addr_bits = ^bus.data_addr[1:0];

  assign bus.data_valid = bus.data_req & sel;
  assign irq            = match_q & irq_en_q;

  // Tick and compare look only at pre-write register state.
  assign tick = en_q & (presc_q == prescale_q);
  assign hit  = tick & (count_q == compare_q);

  always_comb begin
    ctrl_rd                  = '0;
    ctrl_rd[0]               = en_q;
    ctrl_rd[1]               = auto_reload_q;
    ctrl_rd[2]               = irq_en_q;
    ctrl_rd[8 +: PRESCALE_W] = prescale_q;
  end

  // PRESCALE bit i lives at CTRL bit 8+i, i.e. in byte lane (8+i)/8.
  always_comb begin
    prescale_nxt = prescale_q;
    for (int unsigned i = 0; i < PRESCALE_W; i++) begin
      if (bus.data_be[(8 + i) / 8]) prescale_nxt[i] = bus.data_wdata[8 + i];
    end
  end

  // Bus-written lanes override the tick result; other lanes keep it.
  always_comb begin
    count_tick = (hit & auto_reload_q) ? '0 : count_q + 32'd1;
    count_nxt  = tick ? count_tick : count_q;
    if (wr_count) count_nxt = merge(count_nxt, bus.data_wdata, bus.data_be);
  end

  always_comb begin
    bus.data_rdata = '0;
    if (bus.data_req & sel) begin
      case (idx)
        2'd0:    bus.data_rdata = ctrl_rd;
        2'd1:    bus.data_rdata = count_q;
        2'd2:    bus.data_rdata = compare_q;
        default: bus.data_rdata = {31'b0, match_q};
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q          <= 1'b0;
      auto_reload_q <= 1'b0;
      irq_en_q      <= 1'b0;
      prescale_q    <= '0;
      presc_q       <= '0;
      count_q       <= '0;
      compare_q     <= '1;
      match_q       <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        if (bus.data_be[0]) begin
          en_q          <= bus.data_wdata[0];
          auto_reload_q <= bus.data_wdata[1];
          irq_en_q      <= bus.data_wdata[2];
        end
        prescale_q <= prescale_nxt;
      end

      if (wr_ctrl || tick) presc_q <= '0;
      else if (en_q)       presc_q <= presc_q + 1'b1;

      count_q <= count_nxt;

      if (wr_compare) compare_q <= merge(compare_q, bus.data_wdata, bus.data_be);

      // A match on the same cycle as a clear keeps the flag set.
      if (hit)            match_q <= 1'b1;
      else if (clr_match) match_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cva6_timer_periph.sv
// Scoreboard bench for cva6_timer_periph: reads queue expectations, a negedge monitor checks them.
module tb_cva6_timer_periph;

  localparam logic [31:0] A_CTRL   = 32'h2000_1000;
  localparam logic [31:0] A_COUNT  = 32'h2000_1004;
  localparam logic [31:0] A_CMP    = 32'h2000_1008;
  localparam logic [31:0] A_STATUS = 32'h2000_100C;

  logic clk;
  logic reset_n;
  logic irq;

  cva6_timer_periph_if bus ();

  cva6_timer_periph #(
    .BASE_ADDR  (32'h2000_1000),
    .PRESCALE_W (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .irq     (irq)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        valid;
    logic        irq;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] addr,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s addr=%h got=%h expected=%h t=%0t", nm, addr, act, exp, $time);
    end
  endtask

  // Monitor: every read on the bus pops one expectation.
  always @(negedge clk) begin
    if (bus.data_req && !bus.data_we) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_read addr=%h got=%h expected=none", bus.data_addr, bus.data_rdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rdata", e.addr, bus.data_rdata, e.data);
        chk("valid", e.addr, {31'b0, bus.data_valid}, {31'b0, e.valid});
        chk("irq",   e.addr, {31'b0, irq}, {31'b0, e.irq});
      end
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.data_req   = 1'b1;
    bus.data_we    = 1'b1;
    bus.data_addr  = a;
    bus.data_wdata = d;
    bus.data_be    = be;
    @(posedge clk); #1;
    bus.data_req   = 1'b0;
    bus.data_we    = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] ed,
                    input logic ev, input logic ei);
    exp_t e;
    e.addr  = a;
    e.data  = ed;
    e.valid = ev;
    e.irq   = ei;
    sb.push_back(e);
    bus.data_req  = 1'b1;
    bus.data_we   = 1'b0;
    bus.data_addr = a;
    @(posedge clk); #1;
    bus.data_req  = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.data_req   = 1'b0;
    bus.data_we    = 1'b0;
    bus.data_be    = 4'h0;
    bus.data_addr  = '0;
    bus.data_wdata = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset values
    rd(A_CTRL,   32'h0,         1'b1, 1'b0);
    rd(A_COUNT,  32'h0,         1'b1, 1'b0);
    rd(A_CMP,    32'hFFFF_FFFF, 1'b1, 1'b0);
    rd(A_STATUS, 32'h0,         1'b1, 1'b0);

    // Prescale 3: one tick every 4 cycles
    wr(A_CTRL, 32'h0000_0301, 4'hF);
    idle(3);
    rd(A_COUNT, 32'd0,  1'b1, 1'b0);
    rd(A_COUNT, 32'd1,  1'b1, 1'b0);
    idle(35);
    rd(A_COUNT, 32'd10, 1'b1, 1'b0);
    wr(A_CTRL, 32'h0, 4'hF);
    idle(2);
    rd(A_COUNT, 32'd10, 1'b1, 1'b0);

    // Byte lanes, window decode, unimplemented CTRL bits
    wr(A_COUNT, 32'h0, 4'hF);
    wr(A_COUNT, 32'hAABB_CCDD, 4'b0101);
    rd(A_COUNT, 32'h00BB_00DD, 1'b1, 1'b0);
    wr(32'h2000_1010, 32'h1234_5678, 4'hF);
    rd(A_COUNT, 32'h00BB_00DD, 1'b1, 1'b0);
    rd(32'h2000_1010, 32'h0, 1'b0, 1'b0);
    rd(32'h2000_0FFC, 32'h0, 1'b0, 1'b0);
    wr(A_CTRL, 32'hFFFF_FFF8, 4'hF);
    rd(A_CTRL, 32'h0000_FF00, 1'b1, 1'b0);
    wr(A_CTRL, 32'h0, 4'hF);

    // Compare with auto-reload and IRQ, then W1C
    wr(A_COUNT, 32'h0, 4'hF);
    wr(A_CMP,   32'd5, 4'hF);
    wr(A_CTRL,  32'h7, 4'hF);
    idle(5);
    rd(A_COUNT,  32'd5, 1'b1, 1'b0);
    rd(A_STATUS, 32'd1, 1'b1, 1'b1);
    rd(A_COUNT,  32'd1, 1'b1, 1'b1);
    wr(A_CTRL,   32'h4, 4'hF);
    wr(A_STATUS, 32'h0, 4'hF);
    rd(A_STATUS, 32'd1, 1'b1, 1'b1);
    rd(A_COUNT,  32'd3, 1'b1, 1'b1);
    wr(A_STATUS, 32'h1, 4'hF);
    rd(A_STATUS, 32'd0, 1'b1, 1'b0);

    // Wrap without reload
    wr(A_COUNT, 32'hFFFF_FFFE, 4'hF);
    wr(A_CMP,   32'h10, 4'hF);
    wr(A_CTRL,  32'h1, 4'hF);
    rd(A_COUNT, 32'hFFFF_FFFE, 1'b1, 1'b0);
    rd(A_COUNT, 32'hFFFF_FFFF, 1'b1, 1'b0);
    rd(A_COUNT, 32'h0,         1'b1, 1'b0);
    rd(A_COUNT, 32'h1,         1'b1, 1'b0);
    wr(A_CTRL,  32'h0, 4'hF);
    rd(A_STATUS, 32'h0, 1'b1, 1'b0);
    rd(A_COUNT,  32'h3, 1'b1, 1'b0);

    // Collision: W1C on the match cycle
    wr(A_CMP,   32'd2, 4'hF);
    wr(A_COUNT, 32'd0, 4'hF);
    wr(A_CTRL,  32'h1, 4'hF);
    idle(2);
    wr(A_STATUS, 32'h1, 4'hF);
    rd(A_STATUS, 32'd1, 1'b1, 1'b0);
    wr(A_CTRL,   32'h0, 4'hF);
    rd(A_COUNT,  32'd5, 1'b1, 1'b0);
    wr(A_STATUS, 32'h1, 4'hF);
    rd(A_STATUS, 32'd0, 1'b1, 1'b0);

    // Collision: COUNT write on a tick cycle
    wr(A_CTRL,  32'h1, 4'hF);
    wr(A_COUNT, 32'h100, 4'hF);
    rd(A_COUNT, 32'h100, 1'b1, 1'b0);
    rd(A_COUNT, 32'h101, 1'b1, 1'b0);
    wr(A_COUNT, 32'h0000_00AB, 4'b0001);
    rd(A_COUNT, 32'h1AB, 1'b1, 1'b0);
    wr(A_CTRL,  32'h0, 4'hF);
    rd(A_COUNT, 32'h1AD, 1'b1, 1'b0);

    // Reset asserted mid-count with irq high
    wr(A_COUNT, 32'h0, 4'hF);
    wr(A_CMP,   32'd3, 4'hF);
    wr(A_CTRL,  32'h7, 4'hF);
    idle(5);
    rd(A_COUNT, 32'd1, 1'b1, 1'b1);
    reset_n = 1'b0;
    rd(A_CTRL,   32'h0,         1'b1, 1'b0);
    rd(A_COUNT,  32'h0,         1'b1, 1'b0);
    rd(A_CMP,    32'hFFFF_FFFF, 1'b1, 1'b0);
    rd(A_STATUS, 32'h0,         1'b1, 1'b0);
    reset_n = 1'b1;
    idle(2);
    rd(A_COUNT, 32'h0, 1'b1, 1'b0);
    rd(A_CTRL,  32'h0, 1'b1, 1'b0);

    idle(2);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
